// File: rtl/poly_sequencer_if.sv
// Handshake bundle between the stimulus source and poly_sequencer.
//   mode      : evaluation mode, sampled by the sequencer on the A transfer
//   clear     : synchronous abort back to operand intake
//   in_valid  : operand on the datapath data_in is valid
//   in_ready  : sequencer accepts the operand this cycle
//   out_valid : datapath result register holds a finished result
//   out_ready : consumer takes the result
// master = source/consumer side, slave = sequencer side.
interface poly_sequencer_if;
  logic [1:0] mode;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output mode, clear, in_valid, out_ready,
    input  in_ready, out_valid
  );

  modport slave (
    input  mode, clear, in_valid, out_ready,
    output in_ready, out_valid
  );
endinterface

// File: rtl/poly_sequencer.sv
// poly_sequencer: handshaked controller for the 8-bit A/B/C/X polynomial
// datapath. Takes four operands (A, B, C, X) over valid/ready, runs a
// mode-dependent add/multiply microsequence, then holds the result until
// the consumer takes it.
// Ports:
//   clk, resetn        : clock, asynchronous active-low reset
//   hs                 : handshake bundle (mode, clear, in/out valid/ready)
//   ld_a..ld_x, ld_r   : datapath register load enables
//   ld_alu_out         : A/B load source is the ALU output instead of data_in
//   alu_select_a/b     : operand mux selects (0=A, 1=B, 2=C, 3=X)
//   alu_op             : 0 add, 1 multiply
//   busy               : high in the compute states
//   eval_count         : number of results consumed, wraps
module poly_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  poly_sequencer_if.slave  hs,
  output logic             ld_a,
  output logic             ld_b,
  output logic             ld_c,
  output logic             ld_x,
  output logic             ld_r,
  output logic             ld_alu_out,
  output logic [1:0]       alu_select_a,
  output logic [1:0]       alu_select_b,
  output logic             alu_op,
  output logic             busy,
  output logic [CNT_W-1:0] eval_count
);

  localparam int unsigned SEL_W = 2;

  localparam logic [1:0] MODE_QUAD = 2'd0;
  localparam logic [1:0] MODE_LIN  = 2'd1;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  localparam logic [SEL_W-1:0] SEL_A = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_B = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_C = SEL_W'(2);
  localparam logic [SEL_W-1:0] SEL_X = SEL_W'(3);

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef enum logic [3:0] {
    LOAD_A,
    LOAD_B,
    LOAD_C,
    LOAD_X,
    CALC0,
    CALC1,
    CALC2,
    CALC3,
    DONE
  } state_t;

  state_t     state;
  logic [1:0] mode_q;
  logic       in_ready_c;
  logic       out_valid_c;
  logic       xfer;

  assign xfer         = hs.in_valid && in_ready_c;
  assign hs.in_ready  = in_ready_c;
  assign hs.out_valid = out_valid_c;

  // State, latched mode and completed-evaluation counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= LOAD_A;
      mode_q     <= MODE_QUAD;
      eval_count <= '0;
    end else begin
      // Reserved mode is folded into quadratic at capture time so the
      // compute states only ever see 0, 1 or 2.
      if (state == LOAD_A && xfer) begin
        mode_q <= (hs.mode == MODE_RSVD) ? MODE_QUAD : hs.mode;
      end

      if (hs.clear) begin
        state <= LOAD_A;
      end else begin
        case (state)
          LOAD_A: if (xfer) state <= LOAD_B;
          LOAD_B: if (xfer) state <= LOAD_C;
          LOAD_C: if (xfer) state <= LOAD_X;
          LOAD_X: if (xfer) state <= CALC0;
          CALC0:  state <= CALC1;
          CALC1:  state <= (mode_q == MODE_QUAD) ? CALC2 : DONE;
          CALC2:  state <= CALC3;
          CALC3:  state <= DONE;
          DONE: begin
            if (hs.out_ready) begin
              state      <= LOAD_A;
              eval_count <= eval_count + CNT_W'(1);
            end
          end
          default: state <= LOAD_A;
        endcase
      end
    end
  end

  // Output decode; everything is forced low while reset is asserted.
  always_comb begin
    in_ready_c   = 1'b0;
    out_valid_c  = 1'b0;
    ld_a         = 1'b0;
    ld_b         = 1'b0;
    ld_c         = 1'b0;
    ld_x         = 1'b0;
    ld_r         = 1'b0;
    ld_alu_out   = 1'b0;
    alu_select_a = SEL_A;
    alu_select_b = SEL_A;
    alu_op       = OP_ADD;
    busy         = 1'b0;

    if (resetn) begin
      case (state)
        LOAD_A: begin
          in_ready_c = 1'b1;
          ld_a       = hs.in_valid;
        end
        LOAD_B: begin
          in_ready_c = 1'b1;
          ld_b       = hs.in_valid;
        end
        LOAD_C: begin
          in_ready_c = 1'b1;
          ld_c       = hs.in_valid;
        end
        LOAD_X: begin
          in_ready_c = 1'b1;
          ld_x       = hs.in_valid;
        end
        CALC0: begin
          // A <= A*A for square-plus, A <= A*X otherwise.
          busy         = 1'b1;
          ld_a         = 1'b1;
          ld_alu_out   = 1'b1;
          alu_op       = OP_MUL;
          alu_select_a = SEL_A;
          alu_select_b = (mode_q == MODE_QUAD || mode_q == MODE_LIN) ? SEL_X : SEL_A;
        end
        CALC1: begin
          busy         = 1'b1;
          alu_op       = OP_ADD;
          alu_select_a = SEL_A;
          if (mode_q == MODE_QUAD) begin
            // Horner middle step: A <= A+B
            alu_select_b = SEL_B;
            ld_a         = 1'b1;
            ld_alu_out   = 1'b1;
          end else if (mode_q == MODE_LIN) begin
            alu_select_b = SEL_B;
            ld_r         = 1'b1;
          end else begin
            alu_select_b = SEL_C;
            ld_r         = 1'b1;
          end
        end
        CALC2: begin
          busy         = 1'b1;
          ld_a         = 1'b1;
          ld_alu_out   = 1'b1;
          alu_op       = OP_MUL;
          alu_select_a = SEL_A;
          alu_select_b = SEL_X;
        end
        CALC3: begin
          busy         = 1'b1;
          ld_r         = 1'b1;
          alu_op       = OP_ADD;
          alu_select_a = SEL_A;
          alu_select_b = SEL_C;
        end
        DONE: begin
          out_valid_c = 1'b1;
        end
        default: begin
          in_ready_c = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poly_sequencer.sv
// Bench for poly_sequencer: models the 8-bit A/B/C/X/R datapath around the
// sequencer and scoreboards each finished result against the closed-form
// polynomial value.
module tb_poly_sequencer;

  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             resetn;
  logic             ld_a, ld_b, ld_c, ld_x, ld_r, ld_alu_out;
  logic [1:0]       alu_select_a, alu_select_b;
  logic             alu_op, busy;
  logic [CNT_W-1:0] eval_count;

  poly_sequencer_if hs ();

  poly_sequencer #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .hs           (hs.slave),
    .ld_a         (ld_a),
    .ld_b         (ld_b),
    .ld_c         (ld_c),
    .ld_x         (ld_x),
    .ld_r         (ld_r),
    .ld_alu_out   (ld_alu_out),
    .alu_select_a (alu_select_a),
    .alu_select_b (alu_select_b),
    .alu_op       (alu_op),
    .busy         (busy),
    .eval_count   (eval_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model driven by the sequencer controls.
  logic [7:0] data_in;
  logic [7:0] dp_a, dp_b, dp_c, dp_x, dp_r;
  logic [7:0] opnd_a, opnd_b, alu_y;

  function automatic logic [7:0] pick(input logic [1:0] s, input logic [7:0] a, b, c, x);
    case (s)
      2'd0:    return a;
      2'd1:    return b;
      2'd2:    return c;
      default: return x;
    endcase
  endfunction

  always_comb begin
    opnd_a = pick(alu_select_a, dp_a, dp_b, dp_c, dp_x);
    opnd_b = pick(alu_select_b, dp_a, dp_b, dp_c, dp_x);
    alu_y  = alu_op ? 8'(opnd_a * opnd_b) : 8'(opnd_a + opnd_b);
  end

  always @(posedge clk) begin
    if (ld_a) dp_a <= ld_alu_out ? alu_y : data_in;
    if (ld_b) dp_b <= ld_alu_out ? alu_y : data_in;
    if (ld_c) dp_c <= data_in;
    if (ld_x) dp_x <= data_in;
    if (ld_r) dp_r <= alu_y;
  end

  // Scoreboard and counters.
  int         n_cmp = 0;
  int         n_err = 0;
  int         exp_eval = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  function automatic logic [7:0] poly(input logic [1:0] m, input logic [7:0] a, b, c, x);
    case (m)
      2'd1:    return 8'(a * x + b);
      2'd2:    return 8'(a * a + c);
      default: return 8'(a * x * x + b * x + c);
    endcase
  endfunction

  // Pop an expectation whenever the result handshake completes.
  always @(negedge clk) begin
    if (resetn && hs.out_valid && hs.out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL result_unexpected: got %h with no result pending", dp_r);
      end else begin
        mon_exp = exp_q.pop_front();
        if (dp_r !== mon_exp) begin
          n_err++;
          $display("FAIL result: got %h want %h", dp_r, mon_exp);
        end
      end
    end
  end

  // Present A, B, C, X; with gaps, in_valid toggles every cycle. Ends #1
  // after the edge on which X transferred.
  task automatic send_operands(input logic [1:0] m, input logic [7:0] a, b, c, x,
                               input bit gaps);
    logic [7:0] ops[4];
    logic [3:0] ldv, expv;
    bit         phase;
    bit         done;
    int         guard;
    ops   = '{a, b, c, x};
    phase = 1'b0;
    hs.mode = m;
    for (int i = 0; i < 4; i++) begin
      done  = 1'b0;
      guard = 0;
      data_in = ops[i];
      while (!done) begin
        hs.in_valid = gaps ? phase : 1'b1;
        phase = ~phase;
        @(negedge clk);
        if (gaps) begin
          n_cmp++;
          ldv  = {ld_a, ld_b, ld_c, ld_x};
          expv = hs.in_valid ? 4'(4'b1000 >> i) : 4'b0000;
          if (ldv !== expv || ld_r !== 1'b0 || ld_alu_out !== 1'b0) begin
            n_err++;
            $display("FAIL gap_ld op%0d: ld_abcx=%b ld_r=%b alu_out=%b want %b/0/0",
                     i, ldv, ld_r, ld_alu_out, expv);
          end
        end
        done = hs.in_valid && hs.in_ready;
        @(posedge clk);
        #1;
        guard++;
        if (!done && guard > 20) begin
          n_cmp++;
          n_err++;
          $display("FAIL intake_timeout: operand %0d not accepted", i);
          hs.in_valid = 1'b0;
          return;
        end
      end
      // Mode must only be captured on the A transfer.
      if (i == 0) hs.mode = ~m;
    end
    hs.in_valid = 1'b0;
  endtask

  // Full intake plus compute; returns at the negedge where out_valid first shows.
  task automatic run_eval(input logic [1:0] m, input logic [7:0] a, b, c, x,
                          input bit gaps);
    int lat;
    int n;
    send_operands(m, a, b, c, x, gaps);
    exp_q.push_back(poly(m, a, b, c, x));
    lat = (m == 2'd1 || m == 2'd2) ? 2 : 4;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (hs.out_valid) break;
      n_cmp++;
      if (busy !== 1'b1 || hs.in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL compute_flags m%0d cyc%0d: busy=%b in_ready=%b want 1/0",
                 m, n, busy, hs.in_ready);
      end
      if (n > lat + 3) break;
    end
    n_cmp++;
    if (n !== lat + 1) begin
      n_err++;
      $display("FAIL latency m%0d: out_valid on cycle %0d want %0d", m, n, lat + 1);
    end
  endtask

  // Consumes the handshake edge (out_ready already seen high at the last negedge).
  task automatic complete();
    @(posedge clk);
    #1;
    exp_eval++;
    n_cmp++;
    if (eval_count !== CNT_W'(exp_eval) || hs.out_valid !== 1'b0 || hs.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL post_handshake: eval_count=%0d out_valid=%b in_ready=%b want %0d/0/1",
               eval_count, hs.out_valid, hs.in_ready, exp_eval);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    hs.mode = 2'd0; hs.clear = 1'b0; hs.in_valid = 1'b1; hs.out_ready = 1'b1;
    data_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({hs.in_ready, hs.out_valid, busy, ld_a, ld_b, ld_c, ld_x, ld_r, ld_alu_out,
         alu_op, alu_select_a, alu_select_b} !== 14'd0 || eval_count !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: in_ready=%b out_valid=%b ld_a=%b eval_count=%0d want all 0",
               hs.in_ready, hs.out_valid, ld_a, eval_count);
    end
    hs.in_valid = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (hs.in_ready !== 1'b1 || busy !== 1'b0 || hs.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: in_ready=%b busy=%b out_valid=%b want 1/0/0",
               hs.in_ready, busy, hs.out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_quadratic();
    run_eval(2'd0, 8'd2, 8'd3, 8'd5, 8'd4, 1'b0);
    complete();
  endtask

  task automatic test_linear_square();
    run_eval(2'd1, 8'd2, 8'd3, 8'd5, 8'd4, 1'b0);
    complete();
    run_eval(2'd2, 8'd2, 8'd3, 8'd5, 8'd4, 1'b0);
    complete();
  endtask

  task automatic test_overflow();
    run_eval(2'd0, 8'd16, 8'd0, 8'd1, 8'd16, 1'b0);
    complete();
    run_eval(2'd3, 8'd16, 8'd0, 8'd1, 8'd16, 1'b0);
    complete();
  endtask

  task automatic test_backpressure();
    logic [7:0] want;
    want = poly(2'd0, 8'd2, 8'd3, 8'd5, 8'd4);
    hs.out_ready = 1'b0;
    run_eval(2'd0, 8'd2, 8'd3, 8'd5, 8'd4, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      n_cmp++;
      if (hs.out_valid !== 1'b1 || hs.in_ready !== 1'b0 || dp_r !== want ||
          eval_count !== CNT_W'(exp_eval)) begin
        n_err++;
        $display("FAIL backpressure cyc%0d: out_valid=%b in_ready=%b r=%h eval=%0d want 1/0/%h/%0d",
                 i, hs.out_valid, hs.in_ready, dp_r, eval_count, want, exp_eval);
      end
    end
    @(posedge clk);
    #1;
    hs.out_ready = 1'b1;
    @(negedge clk);
    complete();
  endtask

  task automatic test_in_valid_gaps();
    run_eval(2'd0, 8'd7, 8'd9, 8'd11, 8'd3, 1'b1);
    complete();
    run_eval(2'd2, 8'd200, 8'd1, 8'd77, 8'd5, 1'b1);
    complete();
  endtask

  task automatic test_reset_abort();
    send_operands(2'd0, 8'd2, 8'd3, 8'd5, 8'd4, 1'b0);
    @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL abort_setup: busy=%b want 1", busy);
    end
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (ld_r !== 1'b0 || ld_a !== 1'b0 || busy !== 1'b0 || hs.in_ready !== 1'b0 ||
        eval_count !== '0) begin
      n_err++;
      $display("FAIL reset_mid_calc: ld_r=%b ld_a=%b busy=%b in_ready=%b eval=%0d want 0",
               ld_r, ld_a, busy, hs.in_ready, eval_count);
    end
    exp_q.delete();
    exp_eval = 0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (ld_r !== 1'b0 || hs.out_valid !== 1'b0 || hs.in_ready !== 1'b1 || eval_count !== '0) begin
        n_err++;
        $display("FAIL after_reset cyc%0d: ld_r=%b out_valid=%b in_ready=%b eval=%0d want 0/0/1/0",
                 i, ld_r, hs.out_valid, hs.in_ready, eval_count);
      end
    end
    @(posedge clk);
    #1;
    run_eval(2'd0, 8'd2, 8'd3, 8'd5, 8'd4, 1'b0);
    complete();
  endtask

  task automatic test_clear_abort();
    send_operands(2'd0, 8'd2, 8'd3, 8'd5, 8'd4, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    hs.clear = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || ld_a !== 1'b1 || alu_op !== 1'b1 || alu_select_b !== 2'd3) begin
      n_err++;
      $display("FAIL clear_cycle: busy=%b ld_a=%b op=%b sel_b=%0d want 1/1/1/3",
               busy, ld_a, alu_op, alu_select_b);
    end
    @(posedge clk);
    #1;
    hs.clear = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (ld_r !== 1'b0 || hs.out_valid !== 1'b0 || hs.in_ready !== 1'b1 ||
          eval_count !== CNT_W'(exp_eval)) begin
        n_err++;
        $display("FAIL after_clear cyc%0d: ld_r=%b out_valid=%b in_ready=%b eval=%0d want 0/0/1/%0d",
                 i, ld_r, hs.out_valid, hs.in_ready, eval_count, exp_eval);
      end
    end
    @(posedge clk);
    #1;
    run_eval(2'd1, 8'd13, 8'd250, 8'd0, 8'd21, 1'b0);
    complete();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      run_eval(2'(i), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
      complete();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d results still pending want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_quadratic();
    test_linear_square();
    test_overflow();
    test_backpressure();
    test_in_valid_gaps();
    test_reset_abort();
    test_clear_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/poly_sequencer.md
Name: poly_sequencer

Overview:
- Handshaked controller that sequences the 8-bit A/B/C/X polynomial datapath (input registers, two 4:1 ALU operand muxes, add/multiply ALU, result register R).
- Replaces the push-button load FSM with valid/ready operand intake, a mode-selectable compute microsequence and a valid/ready result hold.
- Sits between the stimulus source (switches/debouncer or host) and the datapath; the datapath's data_in is driven directly by the source, not through this block.

Parameters:
CNT_W, 16, width of the completed-evaluation counter eval_count

Ports:
clk  in  1  system clock
resetn  in  1  reset; asynchronous, active-low
mode  in  2  0 quadratic A*X^2+B*X+C; 1 linear A*X+B; 2 square-plus A*A+C; 3 reserved, behaves as 0; sampled on the A transfer
clear  in  1  synchronous abort to LOAD_A
in_valid  in  1  operand on data_in is valid
in_ready  out  1  block accepts the operand this cycle
out_valid  out  1  datapath data_result holds a finished result
out_ready  in  1  consumer takes the result
ld_a, ld_b, ld_c, ld_x, ld_r  out  1 each  datapath register loads
ld_alu_out  out  1  A/B load source is ALU output, not data_in
alu_select_a, alu_select_b  out  2 each  operand mux selects (0=A, 1=B, 2=C, 3=X)
alu_op  out  1  0 add, 1 multiply
busy  out  1  high in any compute state
eval_count  out  CNT_W  number of results consumed, wraps modulo 2^CNT_W

Behaviour:
- States: LOAD_A, LOAD_B, LOAD_C, LOAD_X, CALC0, CALC1, CALC2, CALC3, DONE. The state register and the latched mode register are the only mode-dependent storage.
- Reset: asynchronous assertion forces LOAD_A, latched mode=0 and eval_count=0. While resetn is low, all outputs are 0, including in_ready.
- LOAD_*:
  - in_ready=1.
  - The matching ld_* equals in_valid; ld_alu_out=0.
  - An operand transfers when in_valid&&in_ready; only then does the state advance (A→B→C→X).
  - In LOAD_A the transfer also latches mode.
  - Operand order is fixed: A, B, C, X. All four are loaded in every mode; unused operands are ignored.
- Compute states: outputs are Moore-style and in_ready=0.
  - Mode 0 (quadratic, Horner form):
    - CALC0: A<=A*X (sel 0/3, op 1, ld_a, ld_alu_out).
    - CALC1: A<=A+B (sel 0/1, op 0, ld_a, ld_alu_out).
    - CALC2: A<=A*X.
    - CALC3: R<=A+C (sel 0/2, op 0, ld_r).
  - Mode 1 (linear):
    - CALC0: A<=A*X.
    - CALC1: R<=A+B (sel 0/1, op 0, ld_r).
  - Mode 2 (square-plus):
    - CALC0: A<=A*A (sel 0/0, op 1, ld_a, ld_alu_out).
    - CALC1: R<=A+C (sel 0/2, op 0, ld_r).
  - Modes 1 and 2 go from CALC1 to DONE; mode 0 goes CALC0→CALC1→CALC2→CALC3→DONE.
  - Defaults in every state: all ld_*=0, selects=0, alu_op=0.
- Arithmetic is 8-bit modulo 256 and is truncated in the datapath; the sequencer does no width handling.
- Latency, with X transferring at clock edge k:
  - Mode 0: out_valid=1 from the cycle after edge k+4.
  - Modes 1 and 2: out_valid=1 from the cycle after edge k+2.
- DONE:
  - out_valid=1; in_ready=0; no loads.
  - The state holds for as long as out_ready=0.
  - out_valid&&out_ready moves the state to LOAD_A and increments eval_count.
  - out_ready is ignored in all states other than DONE.
  - R keeps its value after the handshake, until the next ld_r.
- clear: has priority over every other transition. It moves the state to LOAD_A on the next edge and does not increment eval_count. Outputs in the clear cycle are the normal outputs of the current state (a load in that cycle still occurs).
- Async reset mid-compute: the sequence is abandoned and no ld_r is issued; after reset release the block waits in LOAD_A.
- busy=1 exactly in CALC0–CALC3.

Test Plan:
1. Mode 0, A=2, B=3, C=5, X=4, in_valid held high, out_ready=1 -> four intake cycles, out_valid 4 cycles after X transfer, data_result=0x31 (49), eval_count=1.
2. Mode 1 and mode 2 with the same operands -> mode 1: data_result=0x0B (11); mode 2: data_result=0x09; each out_valid 2 cycles after X transfer; eval_count reaches 2 after both.
3. Overflow, mode 0, A=16, B=0, C=1, X=16 -> data_result=0x01; mode 3 with the same operands gives the same result.
4. Backpressure: out_ready low for 10 cycles in DONE -> out_valid stays 1, in_ready stays 0, data_result is stable, eval_count unchanged until the handshake.
5. in_valid gaps (toggled every other cycle during intake) -> ld_* pulse only on valid cycles, the state advances only on transfers, result is still correct.
6. resetn pulsed low during CALC1 (mode 0), and clear asserted in CALC2 on a separate run -> no ld_r, state returns to LOAD_A, out_valid=0; after reset eval_count=0; after clear eval_count is unchanged; a following run completes correctly.
